compare_serial: RTL and testbench
=================================

# compare_serial

Parametrised, digit-serial magnitude comparator with handshakes: the multi-cycle successor of the flat 32-bit combinational compare chain. It accepts an operand pair, scans DIGIT bits per cycle from MSB to LSB, and optionally stops early at the first differing digit. It supports unsigned and two's-complement signed comparison per transaction, and holds the one-hot result under valid/ready backpressure. It sits in datapaths where a full-width compare chain would be too long for the clock period.

## Interface
- WIDTH, 32: operand width in bits; must be a multiple of DIGIT.
- DIGIT, 4: bits compared per cycle; NDIG = WIDTH/DIGIT.
- EARLY_EXIT, 1: 1 stops at the first unequal digit; 0 always scans NDIG digits, giving constant latency.
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  operand pair offered
- in_ready  out  1  block can accept; equals (state==IDLE)
- a, b  in  WIDTH  operands, sampled on the accept edge
- is_signed  in  1  1 = two's-complement compare; sampled with operands
- out_valid  out  1  result valid
- out_ready  in  1  consumer takes result
- agtb, aeqb, altb  out  1 each  registered result; exactly one high while out_valid
- cycles  out  $clog2(NDIG+1)  number of digits examined for this result

## Operation
- The FSM has three states: IDLE, RUN and DONE.
- **IDLE**
  - in_ready=1.
  - An accept (in_valid & in_ready) captures a and b into shift registers.
  - If is_signed=1, the MSB of both captured operands is inverted. This bias makes a subsequent unsigned compare equal to the signed compare.
  - On accept, the digit counter is cleared, the result is cleared to "equal pending", and the FSM goes to RUN.
- **RUN**
  - Each cycle compares the top DIGIT bits of both shift registers, then shifts both left by DIGIT.
  - The cycles counter increments by one per RUN cycle.
  - If the digit differs, the result is latched: agtb if a_digit > b_digit, otherwise altb.
    - EARLY_EXIT=1: the FSM goes to DONE in the same cycle.
    - EARLY_EXIT=0: the first difference stays latched, and later digits cannot overwrite it.
  - After the NDIG-th digit the FSM goes to DONE. If no difference was found, aeqb=1.
- **DONE**
  - out_valid=1; results and cycles are held stable.
  - out_ready=1 moves the FSM to IDLE. out_valid drops on the next edge.
  - No new operand is accepted in the same cycle, because in_ready=0 in DONE.
- After the handshake, result outputs keep their last values until the next DONE. They are meaningful only while out_valid=1.
- in_valid is ignored outside IDLE. a, b and is_signed may change freely after the accept edge.

## Timing
- Reset values: out_valid=0, agtb=0, aeqb=0, altb=0, cycles=0, state=IDLE (so in_ready=1), shift registers 0.
- Reset asserted in any state aborts the transaction immediately. No result is produced, and the block returns to IDLE.
- Let k be the accept edge and j the digits examined (1..NDIG). out_valid rises at edge k+j.
  - EARLY_EXIT=0 or equal operands: j=NDIG.
- Minimum initiation interval is j+2 cycles: RUN for j cycles, DONE for at least 1 cycle, IDLE for 1 cycle.
- out_ready held low keeps DONE indefinitely, with all outputs stable.
- out_ready high on entry to DONE gives a one-cycle out_valid pulse.
- DIGIT=WIDTH is legal and gives single-cycle RUN with j=1 always.

## Structure
- Package compare_pkg holds:
  - the state enum: IDLE, RUN, DONE;
  - cmp_res_t enum: CMP_EQ, CMP_GT, CMP_LT;
  - a function for the $clog2-based cycles width.
- Sub-module compare_digit is a combinational compare of one DIGIT-bit slice, parameterised by DIGIT. It outputs cmp_res_t and generalises the 1-bit cascade cell.
- Top level: FSM, operand shift registers, digit counter, result register and output decode.

## Test plan
Default parameters: WIDTH=32, DIGIT=4, EARLY_EXIT=1 unless stated.
- a=b=0xDEADBEEF, unsigned -> aeqb=1, cycles=8, out_valid at accept+8.
- a=0x80000000, b=0x7FFFFFFF:
  - unsigned -> agtb=1, cycles=1.
  - signed -> altb=1, cycles=1.
- a=0x00000001, b=0x00000002, unsigned -> altb=1, cycles=8.
- EARLY_EXIT=0, a=0xF0000000, b=0 -> agtb=1, cycles=8, and the first-difference result is not overwritten.
- Backpressure: hold out_ready=0 for 5 cycles in DONE while toggling in_valid and a -> out_valid, agtb/aeqb/altb and cycles stay stable, and in_ready=0. Then release -> IDLE next cycle.
- Reset mid-operation: drop rst_n at RUN cycle 3 of an 8-digit compare -> all outputs are at reset values asynchronously. After release, a=0xFFFFFFFF, b=0xFFFFFFFE unsigned -> agtb=1, cycles=8.

Source files
------------

// File: rtl/compare_pkg.sv
// compare_pkg: shared types and helpers for the digit-serial magnitude comparator
// Contents: FSM state enum, digit compare result enum, cycles-counter width helper.
package compare_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  typedef enum logic [1:0] {CMP_EQ, CMP_GT, CMP_LT} cmp_res_t;
  function automatic int cyc_w(input int ndig);
    return $clog2(ndig + 1);
  endfunction
endpackage

// File: rtl/compare_digit.sv
// compare_digit: combinational unsigned magnitude compare of one DIGIT-bit slice
// Ports: a, b - digit slices; res - CMP_GT / CMP_LT / CMP_EQ of a against b.
module compare_digit
  import compare_pkg::*;
#(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  output cmp_res_t         res
);
  assign res = a > b ? CMP_GT : a < b ? CMP_LT : CMP_EQ;
endmodule

// File: rtl/compare_serial.sv
// compare_serial: digit-serial MSB-first magnitude comparator with valid/ready handshakes
// Ports: clk, rst_n (async active-low); in_valid/in_ready with a, b, is_signed;
// out_valid/out_ready with one-hot agtb/aeqb/altb and cycles (digits examined).
module compare_serial
  import compare_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int DIGIT      = 4,
  parameter int EARLY_EXIT = 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [WIDTH-1:0]              a,
  input  logic [WIDTH-1:0]              b,
  input  logic                          is_signed,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic                          agtb,
  output logic                          aeqb,
  output logic                          altb,
  output logic [cyc_w(WIDTH/DIGIT)-1:0] cycles
);
  localparam int NDIG = WIDTH / DIGIT;
  localparam int CW = cyc_w(NDIG);
  localparam logic [CW-1:0] LAST = CW'(NDIG);
  state_t         state;
  logic [WIDTH-1:0] sa, sb, bias;
  logic [CW-1:0]  cnt, cnt_n;
  cmp_res_t       res, res_n, dres;
  logic           fin;
  compare_digit #(.DIGIT(DIGIT)) u_dig (
    .a   (sa[WIDTH-1 -: DIGIT]),
    .b   (sb[WIDTH-1 -: DIGIT]),
    .res (dres)
  );
  // Flipping both sign bits maps two's-complement order onto unsigned order.
  assign bias = WIDTH'(is_signed) << (WIDTH - 1);
  assign in_ready = state == IDLE;
  always_comb begin
    cnt_n = cnt + 1'b1;
    // The first differing digit decides; later digits never overwrite it.
    res_n = res == CMP_EQ ? dres : res;
    fin = cnt_n == LAST || (EARLY_EXIT != 0 && dres != CMP_EQ);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      sa        <= '0;
      sb        <= '0;
      cnt       <= '0;
      res       <= CMP_EQ;
      out_valid <= 1'b0;
      agtb      <= 1'b0;
      aeqb      <= 1'b0;
      altb      <= 1'b0;
      cycles    <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          sa    <= a ^ bias;
          sb    <= b ^ bias;
          cnt   <= '0;
          res   <= CMP_EQ;
          state <= RUN;
        end
        RUN: begin
          sa  <= sa << DIGIT;
          sb  <= sb << DIGIT;
          cnt <= cnt_n;
          res <= res_n;
          if (fin) begin
            state     <= DONE;
            out_valid <= 1'b1;
            agtb      <= res_n == CMP_GT;
            aeqb      <= res_n == CMP_EQ;
            altb      <= res_n == CMP_LT;
            cycles    <= cnt_n;
          end
        end
        DONE: if (out_ready) begin
          state     <= IDLE;
          out_valid <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_compare_serial.sv
// tb_compare_serial: directed self-checking bench for compare_serial (early-exit and constant-latency builds)
module tb_compare_serial;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        iv = 1'b0, ordy = 1'b1, sel = 1'b0;
  logic [31:0] a = '0, b = '0;
  logic        sg = 1'b0;
  logic        ir0, ov0, gt0, eq0, lt0, ir1, ov1, gt1, eq1, lt1;
  logic [3:0]  cy0, cy1;
  logic        ir, ov, gt, eq, lt;
  logic [3:0]  cy;
  int          checks = 0, errors = 0;

  always #5 clk = ~clk;

  compare_serial #(.WIDTH(32), .DIGIT(4), .EARLY_EXIT(1)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv & ~sel), .in_ready(ir0), .a(a), .b(b),
    .is_signed(sg), .out_valid(ov0), .out_ready(ordy | sel), .agtb(gt0), .aeqb(eq0),
    .altb(lt0), .cycles(cy0));

  compare_serial #(.WIDTH(32), .DIGIT(4), .EARLY_EXIT(0)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv & sel), .in_ready(ir1), .a(a), .b(b),
    .is_signed(sg), .out_valid(ov1), .out_ready(ordy | ~sel), .agtb(gt1), .aeqb(eq1),
    .altb(lt1), .cycles(cy1));

  assign ir = sel ? ir1 : ir0;
  assign ov = sel ? ov1 : ov0;
  assign gt = sel ? gt1 : gt0;
  assign eq = sel ? eq1 : eq0;
  assign lt = sel ? lt1 : lt0;
  assign cy = sel ? cy1 : cy0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offers one pair, waits (bounded) for out_valid and checks latency, result and cycles.
  task automatic xact(input string tag, input logic [31:0] xa, input logic [31:0] xb,
                      input logic xs, input logic [2:0] exp_res, input int exp_j);
    int n;
    chk({tag, " in_ready"}, 32'(ir), 32'd1);
    a = xa; b = xb; sg = xs; iv = 1'b1;
    tick();
    iv = 1'b0;
    n = 0;
    while (!ov && n < 20) begin
      tick();
      n++;
    end
    chk({tag, " latency"}, 32'(n), 32'(exp_j));
    chk({tag, " result"}, 32'({gt, eq, lt}), 32'(exp_res));
    chk({tag, " cycles"}, 32'(cy), 32'(exp_j));
  endtask

  initial begin
    #1;
    chk("rst out_valid", 32'(ov0), 32'd0);
    chk("rst in_ready", 32'(ir0), 32'd1);
    chk("rst result", 32'({gt0, eq0, lt0}), 32'd0);
    chk("rst cycles", 32'(cy0), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    xact("eq", 32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 3'b010, 8);
    tick();
    chk("eq pulse out_valid", 32'(ov), 32'd0);
    chk("eq pulse in_ready", 32'(ir), 32'd1);
    xact("u msb", 32'h80000000, 32'h7FFFFFFF, 1'b0, 3'b100, 1);
    tick();
    xact("s msb", 32'h80000000, 32'h7FFFFFFF, 1'b1, 3'b001, 1);
    tick();
    xact("s neg", 32'hFFFFFFFF, 32'h00000001, 1'b1, 3'b001, 1);
    tick();
    xact("u lsb", 32'h00000001, 32'h00000002, 1'b0, 3'b001, 8);
    tick();

    sel = 1'b1;
    xact("ne0 f0", 32'hF0000000, 32'h00000000, 1'b0, 3'b100, 8);
    tick();
    xact("ne0 hold", 32'h10000000, 32'h0FFFFFFF, 1'b0, 3'b100, 8);
    tick();
    sel = 1'b0;

    ordy = 1'b0;
    xact("bp", 32'h00000005, 32'h00000003, 1'b0, 3'b100, 8);
    for (int i = 0; i < 5; i++) begin
      iv = i[0];
      a = 32'h0 - 32'(i);
      tick();
      chk("bp out_valid", 32'(ov), 32'd1);
      chk("bp result", 32'({gt, eq, lt}), 32'b100);
      chk("bp cycles", 32'(cy), 32'd8);
      chk("bp in_ready", 32'(ir), 32'd0);
    end
    iv = 1'b0;
    ordy = 1'b1;
    tick();
    chk("bp release out_valid", 32'(ov), 32'd0);
    chk("bp release in_ready", 32'(ir), 32'd1);
    chk("bp held result", 32'({gt, eq, lt}), 32'b100);

    a = 32'h12345678; b = 32'h12345678; sg = 1'b0; iv = 1'b1;
    tick();
    iv = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    chk("arst out_valid", 32'(ov0), 32'd0);
    chk("arst in_ready", 32'(ir0), 32'd1);
    chk("arst result", 32'({gt0, eq0, lt0}), 32'd0);
    chk("arst cycles", 32'(cy0), 32'd0);
    tick();
    tick();
    chk("arst hold out_valid", 32'(ov0), 32'd0);
    rst_n = 1'b1;
    tick();
    xact("post rst", 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0, 3'b100, 8);
    tick();
    chk("post rst idle", 32'(ir), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
